demultiplexor6_collector: RTL and testbench



---
 rtl/demultiplexor6_collector_pkg.sv | 23 ++
 rtl/demultiplexor6_collector_if.sv | 32 +++
 rtl/demultiplexor6_collector_demultiplexor3.sv | 21 ++
 rtl/demultiplexor6_collector.sv | 107 ++++++++++
 tb/tb_demultiplexor6_collector.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demultiplexor6_collector_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the serial-to-parallel collector and its decoder tree.
//   SEL_W            : select width (6)
//   FRAME_W          : frame width (2**SEL_W = 64)
//   frame_t          : one 64-bit frame, bit i = position i
//   sel_t            : one 6-bit position select
//   collector_state_t: FILL (accepting bits) / FULL (frame presented)
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int SEL_W   = 6;
  localparam int FRAME_W = 1 << SEL_W;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [SEL_W-1:0]   sel_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } collector_state_t;

endpackage : demux_pkg

// File: rtl/demultiplexor6_collector_if.sv
// -----------------------------------------------------------------------------
// demultiplexor6_collector_if
// Bit-input and frame-output handshakes of the collector.
//   master : producer/consumer side (drives in_valid, in_bit, in_sel, auto_inc,
//            clear, out_ready; observes in_ready, ptr, out_data, out_valid)
//   slave  : collector side (the reverse)
// -----------------------------------------------------------------------------
interface demultiplexor6_collector_if;
  import demux_pkg::*;

  logic   in_valid;
  logic   in_ready;
  logic   in_bit;
  sel_t   in_sel;
  logic   auto_inc;
  logic   clear;
  sel_t   ptr;
  frame_t out_data;
  logic   out_valid;
  logic   out_ready;

  modport master (
    output in_valid, in_bit, in_sel, auto_inc, clear, out_ready,
    input  in_ready, ptr, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_bit, in_sel, auto_inc, clear, out_ready,
    output in_ready, ptr, out_data, out_valid
  );

endinterface : demultiplexor6_collector_if

// File: rtl/demultiplexor6_collector_demultiplexor3.sv
// -----------------------------------------------------------------------------
// demultiplexor3
// Combinational 1-to-8 one-hot decoder with enable.
//   en  : input,  1 - when 0 all outputs are 0
//   sel : input,  3 - index of the output to raise
//   y   : output, 8 - one-hot (or all-zero) result
// -----------------------------------------------------------------------------
module demultiplexor3 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule : demultiplexor3

// File: rtl/demultiplexor6_collector.sv
// -----------------------------------------------------------------------------
// demultiplexor6_collector
// Serial-to-parallel collector: accepts one bit per handshake, steers it through
// a 1-to-64 decoder tree into a 64-bit frame register and tracks which
// positions have been written. Once all 64 positions are written the frame is
// held and offered on out_valid/out_ready.
//   clk   : input, 1 - clock, all state changes on the rising edge
//   rst_n : input, 1 - synchronous active-low reset
//   bus   : slave modport of demultiplexor6_collector_if
//           in_valid/in_ready/in_bit/in_sel/auto_inc : bit input handshake
//           clear     : synchronous flush of frame, mask and pointer
//           ptr       : current auto-increment pointer
//           out_data/out_valid/out_ready : frame output handshake
// -----------------------------------------------------------------------------
module demultiplexor6_collector
  import demux_pkg::*;
#(
  parameter int SEL_W = 6  // only 6 is supported
) (
  input logic                          clk,
  input logic                          rst_n,
  demultiplexor6_collector_if.slave    bus
);

  collector_state_t state;
  frame_t           data_q;
  frame_t           mask_q;
  sel_t             ptr_q;

  logic             accept;
  logic [SEL_W-1:0] target;
  logic [7:0]       grp_en;
  frame_t           we;
  frame_t           mask_nxt;
  frame_t           data_nxt;

  // Handshake flags come from the state register alone, so there is no
  // combinational path from in_valid or out_ready to them.
  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.ptr       = ptr_q;

  assign accept = bus.in_valid && (state == FILL);
  assign target = bus.auto_inc ? ptr_q : bus.in_sel;

  // Two-level decoder tree: the upper level picks one group of eight, each
  // lower-level instance picks the bit inside its group. Gating with accept
  // at the top means we is all-zero on any non-accept cycle.
  demultiplexor3 u_dec_hi (
    .en  (accept),
    .sel (target[5:3]),
    .y   (grp_en)
  );

  for (genvar g = 0; g < 8; g++) begin : g_dec_lo
    demultiplexor3 u_dec_lo (
      .en  (grp_en[g]),
      .sel (target[2:0]),
      .y   (we[g*8 +: 8])
    );
  end

  // Rewrites overwrite the data bit; the mask only ever gains bits, so a
  // repeated position cannot advance completion.
  assign mask_nxt = mask_q | we;
  assign data_nxt = (data_q & ~we) | (we & {FRAME_W{bus.in_bit}});

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      data_q <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
    end else if (bus.clear) begin
      // Flush wins over both handshakes; a bit offered this cycle is dropped.
      state  <= FILL;
      data_q <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            data_q <= data_nxt;
            mask_q <= mask_nxt;
            if (bus.auto_inc) ptr_q <= ptr_q + sel_t'(1);  // wraps 63 -> 0
            if (&mask_nxt) state <= FULL;
          end
        end
        FULL: begin
          // Frame data is deliberately kept after hand-off; only the
          // bookkeeping restarts.
          if (bus.out_ready) begin
            state  <= FILL;
            mask_q <= '0;
            ptr_q  <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule : demultiplexor6_collector

// File: tb/tb_demultiplexor6_collector.sv
// -----------------------------------------------------------------------------
// tb_demultiplexor6_collector
// Self-checking bench for demultiplexor6_collector: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a behavioural model built from per-position arrays.
// -----------------------------------------------------------------------------
module tb_demultiplexor6_collector;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  demultiplexor6_collector_if bus ();

  demultiplexor6_collector #(.SEL_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: one entry per frame position.
  bit m_data [64];
  bit m_wr   [64];
  int m_ptr;
  bit m_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_frame();
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = m_data[i];
    return r;
  endfunction

  // Advance one clock: compute the model's next state from the inputs that
  // the DUT sees at this edge, commit it at the edge, then step clear of it.
  task automatic cycle();
    bit nd [64];
    bit nw [64];
    int np;
    bit nf;
    int t;
    int cnt;
    nd = m_data;
    nw = m_wr;
    np = m_ptr;
    nf = m_full;
    if (!rst_n || bus.clear) begin
      for (int i = 0; i < 64; i++) begin
        nd[i] = 1'b0;
        nw[i] = 1'b0;
      end
      np = 0;
      nf = 1'b0;
    end else if (!m_full) begin
      if (bus.in_valid) begin
        t = bus.auto_inc ? m_ptr : int'(bus.in_sel);
        nd[t] = bus.in_bit;
        nw[t] = 1'b1;
        if (bus.auto_inc) np = (m_ptr + 1) % 64;
        cnt = 0;
        for (int i = 0; i < 64; i++) cnt += int'(nw[i]);
        nf = (cnt == 64);
      end
    end else if (bus.out_ready) begin
      for (int i = 0; i < 64; i++) nw[i] = 1'b0;
      np = 0;
      nf = 1'b0;
    end
    @(posedge clk);
    m_data = nd;
    m_wr   = nw;
    m_ptr  = np;
    m_full = nf;
    #1;
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  64'(bus.in_ready),  64'(!m_full));
      check("out_valid", 64'(bus.out_valid), 64'(m_full));
      check("ptr",       64'(bus.ptr),       64'(m_ptr));
      check("out_data",  bus.out_data,       model_frame());
    end
  end

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_sel    = '0;
    bus.auto_inc  = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic send(input logic b, input logic ai, input logic [5:0] s);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.auto_inc = ai;
    bus.in_sel   = s;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic fill_auto(input logic [63:0] v);
    for (int i = 0; i < 64; i++) send(v[i], 1'b1, 6'd0);
  endtask

  task automatic release_frame();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  logic [63:0] pat;
  logic [63:0] held;
  int          perm [64];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_data",      bus.out_data,       64'd0);

    // Auto fill, LSB first.
    pat = 64'hA5A5_0F0F_3C3C_FF00;
    for (int i = 0; i < 63; i++) send(pat[i], 1'b1, 6'd0);
    check("auto_not_full_63", 64'(bus.out_valid), 64'd0);
    send(pat[63], 1'b1, 6'd0);
    check("auto_full",     64'(bus.out_valid), 64'd1);
    check("auto_in_ready", 64'(bus.in_ready),  64'd0);
    check("auto_data",     bus.out_data,       64'hA5A5_0F0F_3C3C_FF00);
    release_frame();
    check("auto_ptr_after", 64'(bus.ptr),      64'd0);
    check("auto_ready_back", 64'(bus.in_ready), 64'd1);
    check("auto_data_kept", bus.out_data,      64'hA5A5_0F0F_3C3C_FF00);

    // Random order over a shuffled permutation, in_bit = sel[0].
    for (int i = 0; i < 64; i++) perm[i] = i;
    for (int i = 63; i > 0; i--) begin
      int j;
      int tmp;
      j = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 63; i++) send(perm[i][0], 1'b0, 6'(perm[i]));
    check("perm_not_full", 64'(bus.out_valid), 64'd0);
    send(perm[63][0], 1'b0, 6'(perm[63]));
    check("perm_full", 64'(bus.out_valid), 64'd1);
    check("perm_data", bus.out_data,       64'hAAAA_AAAA_AAAA_AAAA);
    release_frame();

    // Duplicates: position 5 written 1, 0, 1, then the other 63 with 0.
    send(1'b1, 1'b0, 6'd5);
    send(1'b0, 1'b0, 6'd5);
    send(1'b1, 1'b0, 6'd5);
    for (int i = 0; i < 64; i++) begin
      if (i != 5) begin
        if (i == 63) check("dup_not_full_65", 64'(bus.out_valid), 64'd0);
        send(1'b0, 1'b0, 6'(i));
      end
    end
    check("dup_full_66", 64'(bus.out_valid), 64'd1);
    check("dup_data",    bus.out_data,       64'h0000_0000_0000_0020);
    release_frame();

    // Backpressure: FULL held 10 cycles with stray in_valid pulses.
    pat = {$urandom, $urandom};
    fill_auto(pat);
    held = bus.out_data;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_bit   = ~held[i];
      bus.auto_inc = 1'b0;
      bus.in_sel   = 6'(i);
      cycle();
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_data",     bus.out_data,      held);
    end
    bus.in_valid = 1'b0;
    check("bp_data_pattern", bus.out_data, pat);
    release_frame();
    check("bp_released", 64'(bus.in_ready), 64'd1);

    // Clear mid-frame together with an accept.
    for (int i = 0; i < 20; i++) send(1'b1, 1'b1, 6'd0);
    check("clr_ptr_before", 64'(bus.ptr), 64'd20);
    bus.clear = 1'b1;
    send(1'b1, 1'b1, 6'd0);
    bus.clear = 1'b0;
    check("clr_data", bus.out_data, 64'd0);
    check("clr_ptr",  64'(bus.ptr), 64'd0);
    for (int i = 0; i < 63; i++) send(1'b1, 1'b1, 6'd0);
    check("clr_not_full_63", 64'(bus.out_valid), 64'd0);
    send(1'b1, 1'b1, 6'd0);
    check("clr_full_64", 64'(bus.out_valid), 64'd1);

    // Reset while FULL.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_data",      bus.out_data,       64'd0);
    check("rst_ptr",       64'(bus.ptr),       64'd0);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      bus.in_bit    = 1'($urandom);
      bus.in_sel    = 6'($urandom);
      bus.auto_inc  = ($urandom_range(0, 9) < 7);
      bus.clear     = ($urandom_range(0, 299) == 0);
      bus.out_ready = 1'($urandom);
      rst_n         = ($urandom_range(0, 999) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle_inputs();
    cycle();

    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demultiplexor6_collector
